// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch
// ----------------------------------------------------------------------------
// Program-counter / fetch stage between the instruction BRAM and the decoder.
// Drives the word address and enable of a synchronous instruction memory with
// one cycle of read latency. Tracks the fetch in flight and registers the
// returned word together with its PC for decode. Supports stall, redirect
// (branch/jump) and halt, and sustains one instruction per cycle.
//
// Optional feature macro:
//   FETCH_COUNT_EN - when defined, FetchCount counts consumed instructions
//                    (InstrValid=1 and Stall=0), wrapping mod 2^32.
//                    When undefined, FetchCount is tied to zero and no
//                    counter register exists.
//
// Parameters:
//   RESET_PC       word address fetched first after reset
//
// Ports:
//   Clk            in   1   system clock, rising edge
//   Rst            in   1   synchronous, active-high reset
//   Stall          in   1   decode not accepting; hold fetch state
//   Redirect       in   1   branch/jump taken; flush, restart at RedirectAddr
//   RedirectAddr   in  12   redirect target word address
//   Halt           in   1   stop issuing new fetches
//   ImAddress      out 12   word address to instruction memory
//   ImEna          out  1   instruction memory enable
//   ImInstruction  in  32   memory read data (valid cycle after enable)
//   InstrOut       out 32   registered instruction to decode
//   PcOut          out 12   word address of InstrOut
//   InstrValid     out  1   InstrOut/PcOut hold a live instruction
//   FetchCount     out 32   consumed-instruction counter (see macro above)
// ============================================================================
module instruction_fetch #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [11:0] RedirectAddr,
    input  logic        Halt,
    output logic [11:0] ImAddress,
    output logic        ImEna,
    input  logic [31:0] ImInstruction,
    output logic [31:0] InstrOut,
    output logic [11:0] PcOut,
    output logic        InstrValid,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Next sequential word address; 12-bit arithmetic wraps 4095 -> 0.
    function automatic logic [11:0] pc_incr(input logic [11:0] pc);
        return pc + 12'd1;
    endfunction

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic        inflight_valid_q, inflight_valid_d;
    logic [11:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [11:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;

    logic [11:0] im_address_s;
    logic        im_ena_s;
    logic        capture_s;

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; Redirect outranks Halt and always lands in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Redirect) begin
                    state_d = ST_RUN;
                end else if (Halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (Redirect) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // FSM outputs: memory address and enable. The enable is forced low while
    // Rst is asserted so no read is started during reset.
    always_comb begin
        im_ena_s = 1'b0;
        if (Redirect) begin
            im_address_s = RedirectAddr;
        end else begin
            im_address_s = pc_q;
        end
        if (Rst) begin
            im_ena_s = 1'b0;
        end else begin
            case (state_q)
                ST_RUN:    im_ena_s = Redirect | (~Halt & ~Stall);
                ST_HALTED: im_ena_s = Redirect;
                ST_BOOT:   im_ena_s = 1'b0;
                default:   im_ena_s = 1'b0;
            endcase
        end
    end

    assign ImAddress = im_address_s;
    assign ImEna     = im_ena_s;

    // Fetch tracking: pc and the descriptor of the word currently being read.
    always_comb begin
        pc_d             = pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        if (im_ena_s) begin
            pc_d             = pc_incr(im_address_s);
            inflight_valid_d = 1'b1;
            inflight_pc_d    = im_address_s;
        end else if (!Stall) begin
            inflight_valid_d = 1'b0;
        end else begin
            // Stalled without redirect: everything holds.
            pc_d             = pc_q;
            inflight_valid_d = inflight_valid_q;
            inflight_pc_d    = inflight_pc_q;
        end
    end

    // Decode-side capture. A redirect forces a capture even under stall so
    // the discarded in-flight word is replaced by a bubble; under a plain
    // stall the BRAM output holds because no new read was enabled.
    assign capture_s = ~Stall | Redirect;

    // Output register next-state.
    always_comb begin
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        if (capture_s) begin
            instr_d       = ImInstruction;
            pc_out_d      = inflight_pc_q;
            instr_valid_d = inflight_valid_q & ~Redirect;
        end else begin
            instr_d       = instr_q;
            pc_out_d      = pc_out_q;
            instr_valid_d = instr_valid_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= 12'h000;
            instr_q          <= 32'h0000_0000;
            pc_out_q         <= 12'h000;
            instr_valid_q    <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            instr_q          <= instr_d;
            pc_out_q         <= pc_out_d;
            instr_valid_q    <= instr_valid_d;
        end
    end

    assign InstrOut   = instr_q;
    assign PcOut      = pc_out_q;
    assign InstrValid = instr_valid_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Count consumption cycles: a live instruction that decode accepts.
    always_comb begin
        if (instr_valid_q && !Stall) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Consumed-instruction counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fetch_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign FetchCount = fetch_count_q;
`else
    assign FetchCount = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch
// Directed bench for instruction_fetch. A behavioural BRAM returns
// 32'hA000_0000 + address one cycle after an enabled read and holds its
// output otherwise. Inputs change 1 time unit after each rising edge;
// outputs are compared 1 time unit later.
// ============================================================================
module tb_instruction_fetch;

`ifdef FETCH_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Redirect;
    logic [11:0] RedirectAddr;
    logic        Halt;
    logic [11:0] ImAddress;
    logic        ImEna;
    logic [31:0] ImInstruction;
    logic [31:0] InstrOut;
    logic [11:0] PcOut;
    logic        InstrValid;
    logic [31:0] FetchCount;

    int checks   = 0;
    int failures = 0;

    instruction_fetch #(.RESET_PC(12'h000)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .Halt         (Halt),
        .ImAddress    (ImAddress),
        .ImEna        (ImEna),
        .ImInstruction(ImInstruction),
        .InstrOut     (InstrOut),
        .PcOut        (PcOut),
        .InstrValid   (InstrValid),
        .FetchCount   (FetchCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural synchronous BRAM: word i = A000_0000 + i.
    initial ImInstruction = 32'h0000_0000;
    always @(posedge Clk) begin
        if (ImEna) ImInstruction <= 32'hA000_0000 + 32'(ImAddress);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_deliver(input string tag, input logic [11:0] pc);
        chk({tag, "_valid"}, 32'(InstrValid), 32'd1);
        chk({tag, "_pc"},    32'(PcOut),      32'(pc));
        chk({tag, "_instr"}, InstrOut,        32'hA000_0000 + 32'(pc));
    endtask

    task automatic exp_bubble(input string tag);
        chk({tag, "_valid"}, 32'(InstrValid), 32'd0);
    endtask

    function automatic logic [31:0] cnt(input int n);
        return (CNT_EN != 0) ? 32'(n) : 32'd0;
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 12'h000; Halt = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_pc",    32'(PcOut),      32'd0);
        chk("rst_instr", InstrOut,        32'd0);
        chk("rst_ena",   32'(ImEna),      32'd0);
        chk("rst_cnt",   FetchCount,      32'd0);

        // cycle 0: BOOT, no fetch
        cyc(); Rst = 1'b0; #1;
        chk("boot_ena", 32'(ImEna), 32'd0);
        exp_bubble("boot");
        // cycle 1: first fetch at RESET_PC
        cyc(); #1;
        chk("c1_ena",  32'(ImEna),     32'd1);
        chk("c1_addr", 32'(ImAddress), 32'h000);
        // cycle 2
        cyc(); #1;
        exp_bubble("c2");
        chk("c2_addr", 32'(ImAddress), 32'h001);
        // cycles 3..7: PcOut 0..4
        for (int c = 3; c <= 7; c++) begin
            cyc(); #1;
            exp_deliver("run", 12'(c - 3));
        end

        // cycles 8..10: stall while PcOut=5
        cyc(); Stall = 1'b1; #1;
        exp_deliver("stall_a", 12'h005);
        chk("stall_ena_a", 32'(ImEna), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            exp_deliver("stall_b", 12'h005);
            chk("stall_ena_b", 32'(ImEna), 32'd0);
        end
        // cycle 11: stall released, 5 still shown and now consumed
        cyc(); Stall = 1'b0; #1;
        exp_deliver("stall_end", 12'h005);
        chk("resume_ena",  32'(ImEna),     32'd1);
        chk("resume_addr", 32'(ImAddress), 32'h007);
        cyc(); #1; exp_deliver("after_stall6", 12'h006);
        cyc(); #1; exp_deliver("after_stall7", 12'h007);

        // cycle 14: redirect to 0x100 while PcOut=8
        cyc(); Redirect = 1'b1; RedirectAddr = 12'h100; #1;
        exp_deliver("pre_redir", 12'h008);
        chk("redir_addr", 32'(ImAddress), 32'h100);
        chk("redir_ena",  32'(ImEna),     32'd1);
        chk("cnt_8",      FetchCount,     cnt(8));
        cyc(); Redirect = 1'b0; #1;
        exp_bubble("redir_bubble");
        cyc(); #1; exp_deliver("redir_t0", 12'h100);

        // cycle 17: redirect to 0xFFE to exercise wrap
        cyc(); Redirect = 1'b1; RedirectAddr = 12'hFFE; #1;
        exp_deliver("redir_t1", 12'h101);
        chk("cnt_10", FetchCount, cnt(10));
        cyc(); Redirect = 1'b0; #1;
        exp_bubble("wrap_bubble");
        cyc(); #1;
        exp_deliver("wrap_ffe", 12'hFFE);
        chk("wrap_addr", 32'(ImAddress), 32'h000);
        cyc(); #1; exp_deliver("wrap_fff", 12'hFFF);
        cyc(); #1; exp_deliver("wrap_000", 12'h000);

        // cycle 22: redirect to 0x010, then halt while issuing 20
        cyc(); Redirect = 1'b1; RedirectAddr = 12'h010; #1;
        exp_deliver("wrap_001", 12'h001);
        cyc(); Redirect = 1'b0; #1;
        exp_bubble("h_bubble");
        cyc(); #1; exp_deliver("h_16", 12'h010);
        cyc(); #1; exp_deliver("h_17", 12'h011);
        cyc(); Halt = 1'b1; #1;
        exp_deliver("h_18", 12'h012);
        chk("halt_addr", 32'(ImAddress), 32'h014);
        chk("halt_ena",  32'(ImEna),     32'd0);
        cyc(); Halt = 1'b0; #1;
        exp_deliver("h_19", 12'h013);
        chk("halted_ena", 32'(ImEna), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            exp_bubble("halted");
            chk("halted_ena2", 32'(ImEna), 32'd0);
        end
        // cycle 31: redirect out of HALTED
        cyc(); Redirect = 1'b1; RedirectAddr = 12'h040; #1;
        chk("unhalt_ena",  32'(ImEna),     32'd1);
        chk("unhalt_addr", 32'(ImAddress), 32'h040);
        exp_bubble("unhalt_a");
        cyc(); Redirect = 1'b0; #1;
        exp_bubble("unhalt_b");
        cyc(); #1;
        exp_deliver("unhalt_t", 12'h040);
        chk("cnt_19", FetchCount, cnt(19));

        // cycle 34: redirect during stall takes priority
        cyc(); Stall = 1'b1; Redirect = 1'b1; RedirectAddr = 12'h200; #1;
        exp_deliver("sr_41", 12'h041);
        chk("sr_ena", 32'(ImEna), 32'd1);
        cyc(); Stall = 1'b0; Redirect = 1'b0; #1;
        exp_bubble("sr_bubble");
        cyc(); #1;
        exp_deliver("sr_t", 12'h200);
        chk("cnt_20", FetchCount, cnt(20));

        // cycle 37: reset overrides redirect and stall
        cyc(); Rst = 1'b1; Redirect = 1'b1; Stall = 1'b1; RedirectAddr = 12'h300; #1;
        chk("mrst_ena", 32'(ImEna), 32'd0);
        cyc(); Rst = 1'b0; Redirect = 1'b0; Stall = 1'b0; #1;
        exp_bubble("mrst");
        chk("mrst_pc",   32'(PcOut),  32'd0);
        chk("mrst_ins",  InstrOut,    32'd0);
        chk("mrst_cnt",  FetchCount,  32'd0);
        chk("mrst_ena0", 32'(ImEna),  32'd0);
        cyc(); #1;
        chk("mrst_ena1",  32'(ImEna),     32'd1);
        chk("mrst_addr1", 32'(ImAddress), 32'h000);
        cyc(); #1; exp_bubble("mrst_c2");
        cyc(); #1; exp_deliver("mrst_c3", 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
